// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port unified memory between the IF fetch port and the MEM data port.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed data-first priority.
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  if_stall,
   output logic                  mem_stall,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   logic [1:0]            state_r;
   logic [3:0]            cnt_r;
   logic                  owner_r;
   logic                  mem_cs_r;
   logic                  mem_we_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [DATA_WIDTH-1:0] mem_din_r;
   logic [DATA_WIDTH-1:0] if_rdata_r;
   logic [DATA_WIDTH-1:0] d_rdata_r;
   logic                  grant_d_s;
   logic                  any_req_s;

`ifdef ARB_RR_EN
   logic                  last_owner_r;

   // Grant decision: on a tie, the port that did not own the previous access wins
   always_comb begin
      grant_d_s = 1'b0;
      if (d_req && if_req) begin
         grant_d_s = (last_owner_r == OWN_IF);
      end else begin
         grant_d_s = d_req;
      end
   end

   // Remember the owner of each granted access for the next tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_r <= OWN_IF;
      end else if (state_r == ST_IDLE && any_req_s) begin
         last_owner_r <= grant_d_s;
      end else begin
         last_owner_r <= last_owner_r;
      end
   end
`else
   // Grant decision: data port always beats fetch
   always_comb begin
      grant_d_s = 1'b0;
      if (d_req) begin
         grant_d_s = 1'b1;
      end else begin
         grant_d_s = 1'b0;
      end
   end
`endif

   assign any_req_s = if_req | d_req;

   // Access sequencer; memory-side outputs come only from the latches so requesters may change inputs mid-access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 4'd0;
         owner_r    <= OWN_IF;
         mem_cs_r   <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_addr_r <= '0;
         mem_din_r  <= '0;
         if_rdata_r <= '0;
         d_rdata_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  owner_r    <= grant_d_s;
                  mem_addr_r <= grant_d_s ? d_addr : if_addr;
                  mem_we_r   <= grant_d_s & d_we;
                  mem_din_r  <= d_wdata;
                  mem_cs_r   <= 1'b1;
                  cnt_r      <= CNT_LOAD;
                  state_r    <= ST_BUSY;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  if (!mem_we_r && owner_r == OWN_D) begin
                     d_rdata_r <= mem_dout;
                  end else if (!mem_we_r) begin
                     if_rdata_r <= mem_dout;
                  end else begin
                     d_rdata_r <= d_rdata_r;
                  end
                  mem_cs_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  state_r  <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               mem_cs_r <= 1'b0;
               mem_we_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   // Ack only reaches a requester still waiting for it; a dropped request completes silently
   assign if_ack    = (state_r == ST_RESP) && (owner_r == OWN_IF) && if_req;
   assign d_ack     = (state_r == ST_RESP) && (owner_r == OWN_D) && d_req;
   assign if_stall  = if_req & ~if_ack;
   assign mem_stall = d_req & ~d_ack;

   assign mem_cs    = mem_cs_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_din   = mem_din_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: stimulus queues expected acks, a monitor checks them.
module tb_unified_mem_arbiter;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [31:0] d_wdata = 32'h0;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        if_stall;
   logic        mem_stall;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .if_stall(if_stall), .mem_stall(mem_stall),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: data only valid once mem_cs has been held L cycles
   logic [31:0] mem [0:63];
   int cs_cnt = 0;
   always @(posedge clk) begin
      if (rst) begin
         mem[4] <= 32'h20080005;
         mem[5] <= 32'h8C090044;
      end else if (mem_cs && mem_we && (cs_cnt + 1 >= L)) begin
         mem[mem_addr[7:2]] <= mem_din;
      end
      cs_cnt <= mem_cs ? cs_cnt + 1 : 0;
   end
   assign mem_dout = (mem_cs && (cs_cnt + 1 >= L)) ? mem[mem_addr[7:2]] : 32'hBAD0BAD0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic port, input logic [31:0] data, input logic chk, input int c);
      exp_t e;
      e.port = port; e.data = data; e.chk_data = chk; e.cyc = c;
      sb_q.push_back(e);
   endtask

   // Monitor: every ack pops the scoreboard and is checked for port, cycle and data
   always @(negedge clk) begin
      if (!rst && (if_ack || d_ack)) begin
         exp_t e;
         check("ack_exclusive", {31'd0, if_ack & d_ack}, 32'd0);
         if (sb_q.size() == 0) begin
            check("unexpected_ack", {31'd0, d_ack}, {31'd0, ~d_ack});
         end else begin
            e = sb_q.pop_front();
            check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
            check("ack_cycle", cyc, e.cyc);
            if (e.chk_data) check("ack_rdata", d_ack ? d_rdata : if_rdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic wait_ack(input logic port, input int budget);
      int n = 0;
      while (!(port ? d_ack : if_ack) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check(port ? "d_ack_timeout" : "if_ack_timeout", 32'd0, 32'd1);
      tick();
      if (port) d_req = 1'b0; else if_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      repeat (3) tick();
      at_neg();
      check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Fetch from 0x10
      tick(); t0 = cyc;
      if_addr = 32'h10; if_req = 1'b1;
      push(1'b0, 32'h20080005, 1'b1, t0 + 3);
      at_neg();
      check("t1_stall_c0", {31'd0, if_stall}, 32'd1);
      check("t1_cs_c0", {31'd0, mem_cs}, 32'd0);
      tick(); at_neg();
      check("t1_cs_c1", {31'd0, mem_cs}, 32'd1);
      check("t1_addr_c1", mem_addr, 32'h10);
      check("t1_we_c1", {31'd0, mem_we}, 32'd0);
      check("t1_stall_c1", {31'd0, if_stall}, 32'd1);
      tick(); at_neg();
      check("t1_cs_c2", {31'd0, mem_cs}, 32'd1);
      check("t1_stall_c2", {31'd0, if_stall}, 32'd1);
      tick(); at_neg();
      check("t1_cs_c3", {31'd0, mem_cs}, 32'd0);
      check("t1_stall_c3", {31'd0, if_stall}, 32'd0);
      tick();
      if_req = 1'b0;

      // Store 0xDEADBEEF to 0x40, inputs scrambled after grant
      tick(); t0 = cyc;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
      push(1'b1, 32'h0, 1'b0, t0 + 3);
      tick();
      d_addr = 32'h80; d_wdata = 32'h0; d_we = 1'b0;
      at_neg();
      check("t2_we", {31'd0, mem_we}, 32'd1);
      check("t2_addr", mem_addr, 32'h40);
      check("t2_din", mem_din, 32'hDEADBEEF);
      check("t2_mem_stall", {31'd0, mem_stall}, 32'd1);
      tick(); at_neg();
      check("t2_addr_held", mem_addr, 32'h40);
      check("t2_din_held", mem_din, 32'hDEADBEEF);
      check("t2_we_held", {31'd0, mem_we}, 32'd1);
      wait_ack(1'b1, 8);
      check("t2_rdata_untouched", d_rdata, 32'd0);

      // Load back from 0x40
      tick(); t0 = cyc;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      push(1'b1, 32'hDEADBEEF, 1'b1, t0 + 3);
      wait_ack(1'b1, 8);

      // Simultaneous requests; previous owner was the data port
      tick(); t0 = cyc;
      if_addr = 32'h10; d_addr = 32'h40; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
`ifdef ARB_RR_EN
      push(1'b0, 32'h20080005, 1'b1, t0 + 3);
      push(1'b1, 32'hDEADBEEF, 1'b1, t0 + 7);
`else
      push(1'b1, 32'hDEADBEEF, 1'b1, t0 + 3);
      push(1'b0, 32'h20080005, 1'b1, t0 + 7);
`endif
      fork
         wait_ack(1'b0, 12);
         wait_ack(1'b1, 12);
         begin
            while (cyc < t0 + 6) tick();
            at_neg();
`ifdef ARB_RR_EN
            check("t3_if_stall_c6", {31'd0, if_stall}, 32'd0);
            check("t3_mem_stall_c6", {31'd0, mem_stall}, 32'd1);
`else
            check("t3_if_stall_c6", {31'd0, if_stall}, 32'd1);
            check("t3_mem_stall_c6", {31'd0, mem_stall}, 32'd0);
`endif
         end
      join

      // Fetch dropped in its first BUSY cycle while a load waits
      tick(); t0 = cyc;
      if_addr = 32'h14; if_req = 1'b1;
      push(1'b1, 32'hDEADBEEF, 1'b1, t0 + 7);
      tick();
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      at_neg();
      check("t5_cs_c1", {31'd0, mem_cs}, 32'd1);
      check("t5_mem_stall_c1", {31'd0, mem_stall}, 32'd1);
      tick(); tick(); at_neg();
      check("t5_no_if_ack", {31'd0, if_ack}, 32'd0);
      check("t5_cs_c3", {31'd0, mem_cs}, 32'd0);
      check("t5_mem_stall_c3", {31'd0, mem_stall}, 32'd1);
      tick(); at_neg();
      check("t5_cs_c4", {31'd0, mem_cs}, 32'd0);
      check("t5_if_rdata", if_rdata, 32'h8C090044);
      tick(); at_neg();
      check("t5_cs_c5", {31'd0, mem_cs}, 32'd1);
      check("t5_addr_c5", mem_addr, 32'h40);
      wait_ack(1'b1, 8);

      // Reset during BUSY of a store
      tick(); t0 = cyc;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'h12345678;
      tick(); at_neg();
      check("t6_cs_busy", {31'd0, mem_cs}, 32'd1);
      rst = 1'b1; d_req = 1'b0;
      tick();
      rst = 1'b0;
      at_neg();
      check("t6_cs_after_rst", {31'd0, mem_cs}, 32'd0);
      check("t6_we_after_rst", {31'd0, mem_we}, 32'd0);
      check("t6_addr_after_rst", mem_addr, 32'd0);
      check("t6_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
      tick();
      d_we = 1'b0;
      at_neg();
      check("t6_idle", {31'd0, mem_cs}, 32'd0);
      tick(); t0 = cyc;
      if_addr = 32'h10; if_req = 1'b1;
      push(1'b0, 32'h20080005, 1'b1, t0 + 3);
      wait_ack(1'b0, 8);

      repeat (4) tick();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch (IF) port and the data (MEM-stage) port of the 5-stage MIPS pipeline. A request/acknowledge handshake on each side sequences every memory access over a fixed number of wait cycles. Combinational stall flags tell the pipeline controller to freeze the IF and MEM stages until their access completes. Arbitration is fixed data-first by default; round-robin is available as a compile option.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 2, cycles memory needs with mem_cs held before mem_dout is valid; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  reset (synchronous, active-high)
if_req  input  1  fetch request; held high until if_ack
if_addr  input  ADDR_WIDTH  fetch address
if_rdata  output  DATA_WIDTH  fetched word; valid while if_ack=1
if_ack  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request; held high until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_rdata  output  DATA_WIDTH  load data; valid while d_ack=1
d_ack  output  1  one-cycle completion pulse for data
if_stall  output  1  if_req & ~if_ack (combinational)
mem_stall  output  1  d_req & ~d_ack (combinational)
mem_cs  output  1  memory chip select
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_din  output  DATA_WIDTH  memory write data
mem_dout  input  DATA_WIDTH  memory read data

Behaviour:
- Reset values: state=IDLE, cnt=0, owner=IF, if_ack=d_ack=0, mem_cs=mem_we=0, mem_addr=mem_din=0, if_rdata=d_rdata=0.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: grant one requester.
  - Latch owner, address, we (0 for IF) and wdata.
  - Load cnt=MEM_LATENCY-1 and go to BUSY.
  - Default policy: d_req wins over if_req.
- BUSY: mem_cs=1; mem_addr, mem_we and mem_din come from the latches only, so requester inputs may change freely.
  - cnt>0: decrement cnt.
  - cnt=0: on a read, capture mem_dout into the owner's rdata register; go to RESP.
- RESP: mem_cs=0, mem_we=0.
  - Assert the owner's ack for exactly this one cycle, but only if the owner's req is still high.
  - Always go to IDLE next.
- Request-to-ack latency is MEM_LATENCY+1 cycles after the req is first sampled in IDLE. Peak throughput is one access per MEM_LATENCY+2 cycles.
- RESP never re-arbitrates. The requester's req is still high during its ack cycle and must not be re-granted.
- Request dropped mid-access (e.g. a flush deasserting if_req): the access still runs to completion and a write still commits. The ack is suppressed and the rdata register still updates.
- A write leaves the rdata registers unchanged; d_ack still pulses in RESP.
- Only the owner's ack can be 1; if_ack and d_ack are never high together.
- A non-owner's request stays pending, and its stall flag stays high throughout.
- rst in any state: return to IDLE on the next edge and abandon the access. mem_cs drops on that edge and no ack is issued.
- mem_addr and mem_din hold their last latched values while idle.

Optional Feature:
ARB_RR_EN
- Defined: adds a last_owner register (reset value IF). When both requests are pending in IDLE, the port that did not own the previous access wins.
- Not defined: fixed data-first priority; last_owner logic is absent.
- A single pending request is granted immediately in both builds.

Test Plan:
1. MEM_LATENCY=2; if_req=1, if_addr=0x00000010, memory word 0x20080005 -> mem_cs high 2 cycles, if_ack pulses on cycle 3 with if_rdata=0x20080005; if_stall=1 on cycles 0-2, then 0.
2. d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 with mem_addr=0x40 and mem_din=0xDEADBEEF during BUSY; d_ack on cycle 3; a later load from 0x40 returns 0xDEADBEEF.
3. if_req and d_req both rise in the same cycle (default build) -> data granted first with d_ack at cycle 3; IF granted from IDLE at cycle 4, if_ack at cycle 7; if_stall=1 through cycle 6.
4. Same stimulus with ARB_RR_EN defined and previous owner DATA -> IF granted first (if_ack at cycle 3), then data (d_ack at cycle 7).
5. Drop if_req in the first BUSY cycle -> no if_ack; FSM returns to IDLE at cycle 4; a pending d_req is granted at cycle 4.
6. Assert rst for one cycle during BUSY of a store -> next cycle state=IDLE, mem_cs=0, no ack; a fresh request afterwards completes with normal latency.
